// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared LC-3b pipeline types for the hazard controller: opcodes, instruction
// packet, forward selects, controller states and destination decode helpers.
package pipeline_hazard_controller_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
    OP_JMP  = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef struct packed {
    logic       valid;
    lc3b_opcode opcode;
    logic [2:0] dr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       uses_sr1;
    logic       uses_sr2;
  } lc3b_ipacket;

  typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB} lc3b_fwd_sel;

  typedef enum logic [1:0] {RUN, MEM_WAIT, IND_WAIT} lc3b_hz_state;

  function automatic logic writes_dr(input lc3b_ipacket p);
    logic w;
    case (p.opcode)
      OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDB, OP_LDI, OP_LDR, OP_LEA,
      OP_JSR, OP_TRAP: w = 1'b1;
      default:         w = 1'b0;
    endcase
    return p.valid && w;
  endfunction

  // JSR and TRAP link through R7 regardless of the dr field.
  function automatic logic [2:0] dest_reg(input lc3b_ipacket p);
    return (p.opcode == OP_JSR || p.opcode == OP_TRAP) ? 3'd7 : p.dr;
  endfunction

  function automatic logic is_load(input lc3b_opcode op);
    return op == OP_LDB || op == OP_LDI || op == OP_LDR;
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    return op == OP_LDI || op == OP_STI;
  endfunction

  function automatic logic is_mem_op(input lc3b_ipacket p);
    return p.valid && (is_load(p.opcode) || p.opcode == OP_STB ||
                       p.opcode == OP_STI || p.opcode == OP_STR ||
                       p.opcode == OP_TRAP);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd_compare.sv
// Priority comparator for one EX source operand: MEM writer beats WB writer.
module fwd_compare
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [2:0]  src_reg,
  input  lc3b_ipacket mem_packet,
  input  lc3b_ipacket wb_packet,
  output lc3b_fwd_sel sel
);

  always_comb begin
    sel = FWD_RF;
    if (writes_dr(mem_packet) && dest_reg(mem_packet) == src_reg) begin
      sel = FWD_MEM;
    end else if (writes_dr(wb_packet) && dest_reg(wb_packet) == src_reg) begin
      sel = FWD_WB;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{mem_packet.sr1, mem_packet.sr2, mem_packet.uses_sr1,
                           mem_packet.uses_sr2, wb_packet.sr1, wb_packet.sr2,
                           wb_packet.uses_sr1, wb_packet.uses_sr2};

endmodule

// File: rtl/pipeline_hazard_controller.sv
// LC-3b hazard controller: EX forwarding selects, load-use stall, data memory
// hold (including the two-access LDI/STI sequence) and a stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  lc3b_ipacket      id_packet,
  input  lc3b_ipacket      ex_packet,
  input  lc3b_ipacket      mem_packet,
  input  lc3b_ipacket      wb_packet,
  input  logic             dmem_resp,
  output lc3b_fwd_sel      fwd_sel_a,
  output lc3b_fwd_sel      fwd_sel_b,
  output logic             stall_front,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic             dmem_phase,
  output logic [CNT_W-1:0] stall_cycles,
  output lc3b_hz_state     state_dbg
);

  lc3b_hz_state     state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  lc3b_fwd_sel      sel_a_raw, sel_b_raw;
  logic             mem_op, mem_ind, load_use, mem_hold;

  fwd_compare u_fwd_a (
    .src_reg    (ex_packet.sr1),
    .mem_packet (mem_packet),
    .wb_packet  (wb_packet),
    .sel        (sel_a_raw)
  );

  fwd_compare u_fwd_b (
    .src_reg    (ex_packet.sr2),
    .mem_packet (mem_packet),
    .wb_packet  (wb_packet),
    .sel        (sel_b_raw)
  );

  assign mem_op   = is_mem_op(mem_packet);
  assign mem_ind  = mem_op && is_indirect(mem_packet.opcode);
  assign load_use = ex_packet.valid && is_load(ex_packet.opcode) && id_packet.valid &&
                    ((id_packet.uses_sr1 && id_packet.sr1 == ex_packet.dr) ||
                     (id_packet.uses_sr2 && id_packet.sr2 == ex_packet.dr));

  // An LDI/STI first access holds even when it completes, so the pipeline
  // stays put for the indirect access that follows.
  always_comb begin
    state_d  = state_q;
    mem_hold = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_op && !dmem_resp) begin
          mem_hold = 1'b1;
          state_d  = MEM_WAIT;
        end else if (mem_ind) begin
          mem_hold = 1'b1;
          state_d  = IND_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!dmem_resp) mem_hold = 1'b1;
        else            state_d  = mem_ind ? IND_WAIT : RUN;
      end
      IND_WAIT: begin
        if (!dmem_resp) mem_hold = 1'b1;
        else            state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Memory hold outranks load-use; the latter is only honoured in RUN.
  always_comb begin
    stall_front = !reset && (mem_hold || (state_q == RUN && load_use));
    stall_ex    = !reset && mem_hold;
    stall_mem   = !reset && mem_hold;
    bubble_wb   = !reset && mem_hold;
    bubble_ex   = !reset && !mem_hold && state_q == RUN && load_use;
    dmem_phase  = !reset && state_q == IND_WAIT;
    fwd_sel_a   = reset ? FWD_RF : sel_a_raw;
    fwd_sel_b   = reset ? FWD_RF : sel_b_raw;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_front && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign state_dbg    = state_q;

  logic unused_fields;
  assign unused_fields = ^{id_packet.opcode, id_packet.dr, ex_packet.uses_sr1,
                           ex_packet.uses_sr2};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  lc3b_ipacket      id_packet, ex_packet, mem_packet, wb_packet;
  logic             dmem_resp;
  lc3b_fwd_sel      fwd_sel_a, fwd_sel_b;
  logic             stall_front, stall_ex, stall_mem, bubble_ex, bubble_wb, dmem_phase;
  logic [CNT_W-1:0] stall_cycles;
  lc3b_hz_state     state_dbg;
  logic [5:0]       ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_packet(id_packet), .ex_packet(ex_packet),
    .mem_packet(mem_packet), .wb_packet(wb_packet),
    .dmem_resp(dmem_resp),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_front(stall_front), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .bubble_wb(bubble_wb), .dmem_phase(dmem_phase),
    .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {stall_front, stall_ex, stall_mem, bubble_ex, bubble_wb, dmem_phase}
  assign ctrl = {stall_front, stall_ex, stall_mem, bubble_ex, bubble_wb, dmem_phase};

  localparam lc3b_ipacket NOP = '0;

  function automatic lc3b_ipacket mk(lc3b_opcode op, logic [2:0] dr, logic [2:0] s1,
                                     logic [2:0] s2, logic u1, logic u2);
    lc3b_ipacket p;
    p.valid = 1'b1; p.opcode = op; p.dr = dr; p.sr1 = s1; p.sr2 = s2;
    p.uses_sr1 = u1; p.uses_sr2 = u2;
    return p;
  endfunction

  task automatic idle_inputs();
    id_packet = NOP; ex_packet = NOP; mem_packet = NOP; wb_packet = NOP;
    dmem_resp = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mem_packet = mk(OP_LDR, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0);
    ex_packet  = mk(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 1'b1);
    dmem_resp  = 1'b0;
    @(negedge clk); #2;
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000000", ctrl); end
    n_tests++; if (fwd_sel_a !== FWD_RF) begin n_fail++; $display("FAIL reset_fwd_a got %0d want %0d", fwd_sel_a, FWD_RF); end
    n_tests++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
    n_tests++; if (state_dbg !== RUN) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_dbg, RUN); end
    do_reset();
  endtask

  task automatic test_forward();
    @(negedge clk);
    mem_packet = mk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1);
    wb_packet  = mk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1);
    ex_packet  = mk(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 1'b1);
    #2;
    n_tests++; if (fwd_sel_a !== FWD_MEM) begin n_fail++; $display("FAIL fwd_mem_a got %0d want %0d", fwd_sel_a, FWD_MEM); end
    n_tests++; if (fwd_sel_b !== FWD_MEM) begin n_fail++; $display("FAIL fwd_mem_b got %0d want %0d", fwd_sel_b, FWD_MEM); end
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL fwd_no_stall got %b want 000000", ctrl); end
    @(negedge clk);
    mem_packet = NOP;
    #2;
    n_tests++; if (fwd_sel_a !== FWD_WB) begin n_fail++; $display("FAIL fwd_wb_a got %0d want %0d", fwd_sel_a, FWD_WB); end
    n_tests++; if (fwd_sel_b !== FWD_WB) begin n_fail++; $display("FAIL fwd_wb_b got %0d want %0d", fwd_sel_b, FWD_WB); end
    @(negedge clk);
    ex_packet = mk(OP_ADD, 3'd2, 3'd1, 3'd5, 1'b1, 1'b1);
    mem_packet = mk(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 1'b1);
    mem_packet.valid = 1'b0;
    #2;
    n_tests++; if (fwd_sel_a !== FWD_WB) begin n_fail++; $display("FAIL fwd_split_a got %0d want %0d", fwd_sel_a, FWD_WB); end
    n_tests++; if (fwd_sel_b !== FWD_RF) begin n_fail++; $display("FAIL fwd_invalid_b got %0d want %0d", fwd_sel_b, FWD_RF); end
    @(negedge clk);
    mem_packet = mk(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    wb_packet  = NOP;
    ex_packet  = mk(OP_ADD, 3'd2, 3'd0, 3'd3, 1'b1, 1'b1);
    #2;
    n_tests++; if (fwd_sel_a !== FWD_MEM) begin n_fail++; $display("FAIL fwd_r0_a got %0d want %0d", fwd_sel_a, FWD_MEM); end
    idle_inputs();
  endtask

  task automatic test_jsr();
    @(negedge clk);
    wb_packet  = mk(OP_JSR, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    mem_packet = mk(OP_BR, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0);
    ex_packet  = mk(OP_ADD, 3'd1, 3'd7, 3'd7, 1'b1, 1'b1);
    #2;
    n_tests++; if (fwd_sel_a !== FWD_WB) begin n_fail++; $display("FAIL jsr_wb_a got %0d want %0d", fwd_sel_a, FWD_WB); end
    n_tests++; if (fwd_sel_b !== FWD_WB) begin n_fail++; $display("FAIL jsr_wb_b got %0d want %0d", fwd_sel_b, FWD_WB); end
    @(negedge clk);
    mem_packet = mk(OP_TRAP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    wb_packet  = mk(OP_BR, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0);
    #2;
    n_tests++; if (fwd_sel_a !== FWD_MEM) begin n_fail++; $display("FAIL trap_mem_a got %0d want %0d", fwd_sel_a, FWD_MEM); end
    @(negedge clk);
    mem_packet = NOP;
    #2;
    n_tests++; if (fwd_sel_a !== FWD_RF) begin n_fail++; $display("FAIL br_wb_a got %0d want %0d", fwd_sel_a, FWD_RF); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_packet = mk(OP_LDR, 3'd3, 3'd6, 3'd0, 1'b1, 1'b0);
    id_packet = mk(OP_ADD, 3'd4, 3'd3, 3'd5, 1'b1, 1'b1);
    #2;
    n_tests++; if (ctrl !== 6'b100100) begin n_fail++; $display("FAIL lu_stall got %b want 100100", ctrl); end
    @(negedge clk);
    mem_packet = mk(OP_LDR, 3'd3, 3'd6, 3'd0, 1'b1, 1'b0);
    ex_packet  = NOP;
    #2;
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL lu_release got %b want 000000", ctrl); end
    @(negedge clk);
    ex_packet = mk(OP_ADD, 3'd4, 3'd3, 3'd5, 1'b1, 1'b1);
    id_packet = NOP;
    #2;
    n_tests++; if (fwd_sel_a !== FWD_MEM) begin n_fail++; $display("FAIL lu_fwd got %0d want %0d", fwd_sel_a, FWD_MEM); end
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL lu_nostall got %b want 000000", ctrl); end
    n_tests++; if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    do_reset();
    mem_packet = mk(OP_LDR, 3'd2, 3'd1, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      dmem_resp = (c == 3);
      #2;
      if (stall_front) stalls++;
      if (c == 1) begin
        n_tests++; if (state_dbg !== MEM_WAIT) begin n_fail++; $display("FAIL mw_state got %0d want %0d", state_dbg, MEM_WAIT); end
        n_tests++; if (ctrl !== 6'b111010) begin n_fail++; $display("FAIL mw_ctrl got %b want 111010", ctrl); end
      end
    end
    n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL mw_stalls got %0d want 3", stalls); end
    @(negedge clk);
    mem_packet = NOP;
    #2;
    n_tests++; if (state_dbg !== RUN) begin n_fail++; $display("FAIL mw_back_run got %0d want %0d", state_dbg, RUN); end
    n_tests++; if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL mw_cnt got %0d want 3", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_ldi();
    do_reset();
    mem_packet = mk(OP_LDI, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0);
    dmem_resp  = 1'b1;
    #2;
    n_tests++; if (ctrl !== 6'b111010) begin n_fail++; $display("FAIL ldi_first got %b want 111010", ctrl); end
    @(negedge clk); #2;
    n_tests++; if (state_dbg !== IND_WAIT) begin n_fail++; $display("FAIL ldi_state got %0d want %0d", state_dbg, IND_WAIT); end
    n_tests++; if (ctrl !== 6'b000001) begin n_fail++; $display("FAIL ldi_second got %b want 000001", ctrl); end
    @(negedge clk);
    mem_packet = NOP;
    #2;
    n_tests++; if (state_dbg !== RUN || dmem_phase !== 1'b0) begin n_fail++; $display("FAIL ldi_done state %0d phase %b want %0d 0", state_dbg, dmem_phase, RUN); end
    n_tests++; if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL ldi_cnt got %0d want 1", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_overlap();
    do_reset();
    mem_packet = mk(OP_STR, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);
    ex_packet  = mk(OP_LDB, 3'd3, 3'd6, 3'd0, 1'b1, 1'b0);
    id_packet  = mk(OP_AND, 3'd4, 3'd5, 3'd3, 1'b1, 1'b1);
    dmem_resp  = 1'b0;
    #2;
    n_tests++; if (ctrl !== 6'b111010) begin n_fail++; $display("FAIL ov_hold got %b want 111010", ctrl); end
    @(negedge clk);
    dmem_resp = 1'b1;
    #2;
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL ov_release got %b want 000000", ctrl); end
    @(negedge clk);
    mem_packet = NOP;
    #2;
    n_tests++; if (ctrl !== 6'b100100) begin n_fail++; $display("FAIL ov_loaduse got %b want 100100", ctrl); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    mem_packet = mk(OP_STB, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);
    dmem_resp  = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    n_tests++; if (stall_cycles !== 4'hF) begin n_fail++; $display("FAIL sat_cnt got %0d want 15", stall_cycles); end
    n_tests++; if (stall_front !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %b want 1", stall_front); end
    @(negedge clk); #2;
    n_tests++; if (stall_cycles !== 4'hF) begin n_fail++; $display("FAIL sat_hold got %0d want 15", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_packet = mk(OP_STI, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    wb_packet = mk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1);
    ex_packet = mk(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 1'b1);
    #2;
    n_tests++; if (ctrl !== 6'b111011) begin n_fail++; $display("FAIL rm_ind_hold got %b want 111011", ctrl); end
    n_tests++; if (fwd_sel_a !== FWD_WB) begin n_fail++; $display("FAIL rm_pre_fwd got %0d want %0d", fwd_sel_a, FWD_WB); end
    reset = 1'b1;
    #1;
    n_tests++; if (ctrl !== 6'b000000) begin n_fail++; $display("FAIL rm_ctrl got %b want 000000", ctrl); end
    n_tests++; if (fwd_sel_a !== FWD_RF || fwd_sel_b !== FWD_RF) begin n_fail++; $display("FAIL rm_fwd got %0d/%0d want %0d", fwd_sel_a, fwd_sel_b, FWD_RF); end
    n_tests++; if (state_dbg !== RUN || stall_cycles !== 4'd0) begin n_fail++; $display("FAIL rm_regs state %0d cnt %0d want %0d 0", state_dbg, stall_cycles, RUN); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk); #2;
    n_tests++; if (state_dbg !== RUN || stall_cycles !== 4'd0) begin n_fail++; $display("FAIL rm_after state %0d cnt %0d want %0d 0", state_dbg, stall_cycles, RUN); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_jsr();
    test_load_use();
    test_mem_wait();
    test_ldi();
    test_overlap();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
